// File: rtl/pdm_cic_array_if.sv
// ----------------------------------------------------------------------------
// pdm_cic_array_if
//   PCM output channel of the PDM CIC decimator array. It carries one frame
//   of NCH unsigned samples per handshake, with a sequence number and a
//   sticky overrun flag.
//
//   Signals:
//     out_valid    producer -> consumer  frame available
//     out_ready    consumer -> producer  frame accepted when valid && ready
//     out_data     producer -> consumer  channel i at [i*OUT_W +: OUT_W]
//     out_seq      producer -> consumer  computed-sample index of the frame
//     overrun      producer -> consumer  sticky: a frame was overwritten
//     overrun_clr  consumer -> producer  one-cycle clear of overrun
//
//   Modports: master (decimator side), slave (back-end side).
// ----------------------------------------------------------------------------
interface pdm_cic_array_if #(
    parameter int NCH   = 2,
    parameter int OUT_W = 16,
    parameter int SEQ_W = 8
);
    logic                 out_valid;
    logic                 out_ready;
    logic [NCH*OUT_W-1:0] out_data;
    logic [SEQ_W-1:0]     out_seq;
    logic                 overrun;
    logic                 overrun_clr;

    modport master (
        output out_valid,
        output out_data,
        output out_seq,
        output overrun,
        input  out_ready,
        input  overrun_clr
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_seq,
        input  overrun,
        output out_ready,
        output overrun_clr
    );
endinterface

// File: rtl/pdm_cic_array.sv
// ----------------------------------------------------------------------------
// pdm_cic_array
//   Multi-channel PDM-to-PCM CIC decimator. NCH microphone bits are sampled
//   on each pdm_ce strobe and fed through ORDER integrators per channel. Once
//   every DECIM strobes the last integrator is captured and pushed through an
//   ORDER-stage comb pipeline (one stage per clk). Each comb result is
//   truncated to its OUT_W most significant bits and presented as one frame
//   on a valid/ready channel.
//
//   Ports:
//     clk       system clock
//     rst_n     asynchronous active-low reset
//     pdm_ce    one-clk strobe per PDM sample
//     pdm_data  NCH mic bits, bit i = channel i, sampled when pdm_ce=1
//     pcm       pdm_cic_array_if.master: out_valid/out_ready/out_data/
//               out_seq/overrun/overrun_clr
//
//   Parameters: NCH, ORDER (1..5), DECIM (power of two, >= ORDER+2),
//   OUT_W (<= ACC_W), SEQ_W, MARK_PERIOD. ACC_W = ORDER*log2(DECIM)+1 is
//   derived and cannot be overridden.
//
//   Optional build macro CIC_FRAME_MARK_EN: when defined, every emitted frame
//   whose out_seq mod MARK_PERIOD equals MARK_PERIOD-1 carries all ones on
//   channel 0 as a host alignment marker. When undefined no marker logic is
//   built and MARK_PERIOD is ignored.
// ----------------------------------------------------------------------------
module pdm_cic_array #(
    parameter int NCH         = 2,
    parameter int ORDER       = 3,
    parameter int DECIM       = 256,
    parameter int OUT_W       = 16,
    parameter int SEQ_W       = 8,
    parameter int MARK_PERIOD = 512
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           pdm_ce,
    input  logic [NCH-1:0] pdm_data,
    pdm_cic_array_if.master pcm
);

    // Bit growth of an ORDER-stage CIC with ratio DECIM is ORDER*log2(DECIM);
    // the extra bit keeps the full-scale value 2^(ORDER*log2(DECIM)) exact.
    localparam int ACC_W  = ORDER * $clog2(DECIM) + 1;
    localparam int CNT_W  = $clog2(DECIM);
    localparam int WARM_W = $clog2(ORDER + 1);

    if (NCH < 1) begin : g_bad_nch
        $error("pdm_cic_array: NCH must be >= 1");
    end
    if (ORDER < 1 || ORDER > 5) begin : g_bad_order
        $error("pdm_cic_array: ORDER must be in 1..5");
    end
    if ((DECIM & (DECIM - 1)) != 0 || DECIM < ORDER + 2) begin : g_bad_decim
        $error("pdm_cic_array: DECIM must be a power of two and >= ORDER+2");
    end
    if (OUT_W < 1 || OUT_W > ACC_W) begin : g_bad_out_w
        $error("pdm_cic_array: OUT_W must be in 1..ACC_W");
    end
    if (MARK_PERIOD < 1) begin : g_bad_mark_period
        $error("pdm_cic_array: MARK_PERIOD must be >= 1");
    end

    // MSB truncation of a comb result, no rounding. Shifting the whole word
    // keeps the conversion a plain bit selection.
    function automatic logic [OUT_W-1:0] trunc_out(input logic [ACC_W-1:0] v);
        return OUT_W'(v >> (ACC_W - OUT_W));
    endfunction

`ifdef CIC_FRAME_MARK_EN
    function automatic logic is_mark(input logic [SEQ_W-1:0] s);
        return (32'(s) % MARK_PERIOD) == (MARK_PERIOD - 1);
    endfunction
`endif

    logic [CNT_W-1:0]  dec_cnt;
    logic              tick;
    logic [ACC_W-1:0]  integ    [NCH][ORDER];
    logic [ACC_W-1:0]  cap_p0   [NCH];
    logic [ACC_W-1:0]  comb_in  [NCH][ORDER];
    logic [ACC_W-1:0]  comb_p   [NCH][ORDER];
    logic [ACC_W-1:0]  comb_dly [NCH][ORDER];
    // vld_p[0]: capture register holds a new sample;
    // vld_p[k]: comb stage k holds a new result (k = 1..ORDER).
    logic [ORDER:0]    vld_p;
    logic [WARM_W-1:0] warm_cnt;
    logic [SEQ_W-1:0]  seq_cnt;
    logic              warm_done;
    logic              load;
    logic              emit;
    logic [NCH*OUT_W-1:0] frame;

    assign tick = pdm_ce && (dec_cnt == CNT_W'(DECIM - 1));

    // ---- integrator section: advances only on pdm_ce ----
    // DECIM is a power of two, so the counter wraps to 0 on its own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_cnt <= '0;
        end else if (pdm_ce) begin
            dec_cnt <= dec_cnt + CNT_W'(1);
        end
    end

    // Every stage adds the pre-edge value of the stage before it, so each
    // stage is one register; wrap-around modulo 2^ACC_W is cancelled by the
    // combs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < NCH; ch++) begin
                for (int k = 0; k < ORDER; k++) begin
                    integ[ch][k] <= '0;
                end
            end
        end else if (pdm_ce) begin
            for (int ch = 0; ch < NCH; ch++) begin
                integ[ch][0] <= integ[ch][0] + ACC_W'(pdm_data[ch]);
                for (int k = 1; k < ORDER; k++) begin
                    integ[ch][k] <= integ[ch][k] + integ[ch][k-1];
                end
            end
        end
    end

    // ---- p0: decimated capture of the last integrator ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < NCH; ch++) begin
                cap_p0[ch] <= '0;
            end
        end else if (tick) begin
            for (int ch = 0; ch < NCH; ch++) begin
                cap_p0[ch] <= integ[ch][ORDER-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
        end else begin
            vld_p <= {vld_p[ORDER-1:0], tick};
        end
    end

    // ---- p1..pORDER: comb pipeline, one stage per clk ----
    always_comb begin
        for (int ch = 0; ch < NCH; ch++) begin
            comb_in[ch][0] = cap_p0[ch];
            for (int k = 1; k < ORDER; k++) begin
                comb_in[ch][k] = comb_p[ch][k-1];
            end
        end
    end

    // The differential delay is one decimated sample, so each delay register
    // moves only when its stage sees a new sample, not on every clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < NCH; ch++) begin
                for (int k = 0; k < ORDER; k++) begin
                    comb_p[ch][k]   <= '0;
                    comb_dly[ch][k] <= '0;
                end
            end
        end else begin
            for (int k = 0; k < ORDER; k++) begin
                if (vld_p[k]) begin
                    for (int ch = 0; ch < NCH; ch++) begin
                        comb_p[ch][k]   <= comb_in[ch][k] - comb_dly[ch][k];
                        comb_dly[ch][k] <= comb_in[ch][k];
                    end
                end
            end
        end
    end

    // ---- output register: warm-up gating, sequence and handshake ----
    // The first ORDER results still contain the comb start-up transient;
    // they are counted in out_seq but never presented.
    assign load      = vld_p[ORDER];
    assign warm_done = (warm_cnt == WARM_W'(ORDER));
    assign emit      = load && warm_done;

    always_comb begin
        frame = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            frame[ch*OUT_W +: OUT_W] = trunc_out(comb_p[ch][ORDER-1]);
        end
`ifdef CIC_FRAME_MARK_EN
        if (is_mark(seq_cnt)) begin
            frame[OUT_W-1:0] = '1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm_cnt      <= '0;
            seq_cnt       <= '0;
            pcm.out_valid <= 1'b0;
            pcm.out_data  <= '0;
            pcm.out_seq   <= '0;
            pcm.overrun   <= 1'b0;
        end else begin
            if (load) begin
                seq_cnt <= seq_cnt + SEQ_W'(1);
                if (!warm_done) begin
                    warm_cnt <= warm_cnt + WARM_W'(1);
                end
            end

            // A load wins over acceptance on the same edge: the new frame
            // replaces the accepted one and valid simply stays high.
            if (emit) begin
                pcm.out_valid <= 1'b1;
                pcm.out_data  <= frame;
                pcm.out_seq   <= seq_cnt;
            end else if (pcm.out_valid && pcm.out_ready) begin
                pcm.out_valid <= 1'b0;
            end

            // Setting has priority over a simultaneous clear.
            if (emit && pcm.out_valid && !pcm.out_ready) begin
                pcm.overrun <= 1'b1;
            end else if (pcm.overrun_clr) begin
                pcm.overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pdm_cic_array.sv
// ----------------------------------------------------------------------------
// tb_pdm_cic_array
//   Directed bench for pdm_cic_array: NCH=2, ORDER=3, DECIM=64, OUT_W=16
//   (ACC_W=19), pdm_ce every 4 clks. Full-scale output for an all-ones
//   channel is 64^3 = 2^18 -> top 16 of 19 bits = 0x8000; a 1010 pattern
//   gives half of that, 0x4000.
// ----------------------------------------------------------------------------
module tb_pdm_cic_array;

    localparam int NCH         = 2;
    localparam int ORDER       = 3;
    localparam int DECIM       = 64;
    localparam int OUT_W       = 16;
    localparam int SEQ_W       = 8;
    localparam int MARK_PERIOD = 8;
    localparam int PERIOD      = DECIM * 4;

`ifdef CIC_FRAME_MARK_EN
    localparam bit MARK_ON = 1'b1;
`else
    localparam bit MARK_ON = 1'b0;
`endif

    logic           clk      = 1'b0;
    logic           rst_n    = 1'b0;
    logic           pdm_ce   = 1'b0;
    logic [NCH-1:0] pdm_data = '0;

    int   vectors     = 0;
    int   miscompares = 0;
    int   ph          = 0;
    int   mode0       = 1;   // 0: zeros, 1: ones, 2: alternating
    int   mode1       = 0;
    logic alt         = 1'b0;

    pdm_cic_array_if #(.NCH(NCH), .OUT_W(OUT_W), .SEQ_W(SEQ_W)) pcm ();

    pdm_cic_array #(
        .NCH(NCH), .ORDER(ORDER), .DECIM(DECIM), .OUT_W(OUT_W),
        .SEQ_W(SEQ_W), .MARK_PERIOD(MARK_PERIOD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pdm_ce(pdm_ce),
        .pdm_data(pdm_data),
        .pcm(pcm)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic src(input int mode, input logic a);
        return (mode == 2) ? a : (mode == 1);
    endfunction

    function automatic logic [31:0] exp_frame(input logic [15:0] c0, input logic [15:0] c1,
                                              input logic [7:0] seq);
        logic [15:0] e0;
        e0 = c0;
        if (MARK_ON && ((seq % 8'd8) == 8'd7)) e0 = 16'hFFFF;
        return {c1, e0};
    endfunction

    // One clk: inputs change on the falling edge; outputs are read there too.
    task automatic cyc();
        @(negedge clk);
        pdm_ce = (ph == 0);
        if (ph == 0) begin
            alt = ~alt;
            pdm_data[0] = src(mode0, alt);
            pdm_data[1] = src(mode1, alt);
        end
        ph = (ph + 1) % 4;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Steps until a new frame is presented (valid with a changed out_seq).
    task automatic wait_load(input string tag);
        logic [SEQ_W-1:0] s0;
        bit seen;
        s0   = pcm.out_seq;
        seen = 1'b0;
        for (int i = 0; i < 6 * PERIOD && !seen; i++) begin
            cyc();
            if (pcm.out_valid && pcm.out_seq != s0) seen = 1'b1;
        end
        vectors++;
        assert (seen) else begin
            miscompares++;
            $error("FAIL %s observed=no_frame expected=frame_within_bound", tag);
        end
    endtask

    initial begin
        pcm.out_ready   = 1'b1;
        pcm.overrun_clr = 1'b0;

        // reset state
        repeat (3) cyc();
        check("rst_valid",   pcm.out_valid, 0);
        check("rst_seq",     pcm.out_seq,   0);
        check("rst_data",    pcm.out_data,  0);
        check("rst_overrun", pcm.overrun,   0);
        rst_n = 1'b1;

        // ch0 ones, ch1 zeros: three samples suppressed, first emitted seq 3
        wait_load("first_frame");
        check("warmup_seq", pcm.out_seq, 3);
        cyc();
        check("valid_drop_after_accept", pcm.out_valid, 0);
        for (int n = 4; n <= 5; n++) begin
            wait_load("ones_load");
            check("ones_seq",  pcm.out_seq,  n);
            check("ones_data", pcm.out_data, exp_frame(16'h8000, 16'h0000, 8'(n)));
        end

        // asynchronous reset about 30 strobes into the next frame
        repeat (116) cyc();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid",   pcm.out_valid, 0);
        check("midrst_seq",     pcm.out_seq,   0);
        check("midrst_data",    pcm.out_data,  0);
        check("midrst_overrun", pcm.overrun,   0);
        cyc();
        rst_n = 1'b1;
        mode0 = 2;
        mode1 = 1;
        check("midrst_hold_valid", pcm.out_valid, 0);

        // ch0 1010..., ch1 ones; warm-up repeats
        wait_load("rst_first");
        check("rst_warmup_seq", pcm.out_seq, 3);
        for (int n = 4; n <= 5; n++) begin
            wait_load("alt_load");
            check("alt_seq",  pcm.out_seq,  n);
            check("alt_data", pcm.out_data, exp_frame(16'h4000, 16'h8000, 8'(n)));
        end
        cyc();

        // stall for three sample periods: 6 and 7 are dropped, 8 is delivered
        pcm.out_ready = 1'b0;
        wait_load("stall_first");
        check("stall_seq",     pcm.out_seq,  6);
        check("stall_ovr",     pcm.overrun,  0);
        check("stall_data",    pcm.out_data, exp_frame(16'h4000, 16'h8000, 8'd6));
        repeat (20) cyc();
        check("hold_valid",    pcm.out_valid, 1);
        check("hold_seq",      pcm.out_seq,   6);
        check("hold_data",     pcm.out_data,  exp_frame(16'h4000, 16'h8000, 8'd6));
        wait_load("stall_second");
        check("overwrite_seq", pcm.out_seq,  7);
        check("overwrite_ovr", pcm.overrun,  1);
        wait_load("stall_third");
        check("drop_gap_seq",  pcm.out_seq,  8);
        pcm.out_ready = 1'b1;
        cyc();
        check("stall_accept_valid", pcm.out_valid, 0);
        check("overrun_sticky",     pcm.overrun,   1);
        pcm.overrun_clr = 1'b1;
        cyc();
        pcm.overrun_clr = 1'b0;
        check("overrun_cleared", pcm.overrun, 0);

        // acceptance on the same edge as the next load
        pcm.out_ready = 1'b0;
        wait_load("edge_first");
        check("edge_first_seq", pcm.out_seq, 9);
        repeat (PERIOD - 1) cyc();
        check("edge_pre_seq", pcm.out_seq, 9);
        pcm.out_ready = 1'b1;
        cyc();
        check("edge_valid",   pcm.out_valid, 1);
        check("edge_seq",     pcm.out_seq,   10);
        check("edge_overrun", pcm.overrun,   0);
        check("edge_data",    pcm.out_data,  exp_frame(16'h4000, 16'h8000, 8'd10));
        cyc();
        check("edge_release_valid", pcm.out_valid, 0);

        // ch0 zeros, ch1 ones; marker frames (seq mod 8 == 7) when enabled
        mode0 = 0;
        mode1 = 1;
        repeat (4) wait_load("settle");
        for (int n = 15; n <= 24; n++) begin
            wait_load("zero_load");
            check("zero_seq",  pcm.out_seq,  n);
            check("zero_data", pcm.out_data, exp_frame(16'h0000, 16'h8000, 8'(n)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
